// File: rtl/oldland_fetch_pkg.sv
// oldland_defs: shared constants and encodings for the oldland fetch stage
package oldland_defs;
    localparam logic [31:0] OLDLAND_NOP          = 32'h1C00_0000;
    localparam logic [31:0] OLDLAND_RESET_VECTOR = 32'h1000_0000;

    typedef enum logic [1:0] {ST_IDLE, ST_FETCH, ST_HOLD, ST_FLUSH} fetch_state_t;
    typedef enum logic [1:0] {OUT_KEEP, OUT_BUBBLE, OUT_MEM, OUT_SKID} out_sel_t;

    function automatic logic [31:0] word_align(input logic [31:0] a);
        return a & ~32'h3;
    endfunction
endpackage

// File: rtl/oldland_fetch_if.sv
// oldland_fetch_if: instruction memory request/acknowledge bus
interface oldland_fetch_if;
    logic [31:0] i_addr;
    logic        i_access;
    logic        i_ack;
    logic [31:0] i_data;

    modport master(output i_addr, i_access, input i_ack, i_data);
    modport slave(input i_addr, i_access, output i_ack, i_data);
endinterface

// File: rtl/oldland_fetch_skid.sv
// oldland_fetch_skid: one-entry holding register for a word acked while decode stalls
module oldland_fetch_skid (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        clear,
    input  logic [31:0] d_instr,
    input  logic [31:0] d_pc_plus_4,
    output logic [31:0] q_instr,
    output logic [31:0] q_pc_plus_4,
    output logic        valid
);
    // capture on load; clear wins so a redirect always empties the entry
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            valid <= 1'b0;
        end else if (load) begin
            valid       <= 1'b1;
            q_instr     <= d_instr;
            q_pc_plus_4 <= d_pc_plus_4;
        end
    end
endmodule

// File: rtl/oldland_fetch.sv
// oldland_fetch: instruction fetch stage with stall skid, redirect flush and debug run/stop
module oldland_fetch
    import oldland_defs::*;
#(
    parameter logic [31:0] RESET_VECTOR = OLDLAND_RESET_VECTOR,
    parameter logic [31:0] NOP_INSTR    = OLDLAND_NOP
) (
    input  logic               clk,
    input  logic               rst,
    oldland_fetch_if.master    mem,
    input  logic               stall,
    input  logic               branch_taken,
    input  logic [31:0]        branch_pc,
    input  logic               run,
    output logic               stopped,
    input  logic               pc_wr_en,
    input  logic [31:0]        pc_wr_val,
    output logic [31:0]        instr,
    output logic [31:0]        pc_plus_4,
    output logic               i_fetched
);
    fetch_state_t state, state_next, resume;
    out_sel_t     out_sel;
    logic [31:0]  fetch_pc, pc_next, target, target_next, pc_inc;
    logic [31:0]  skid_instr, skid_pc_plus_4;
    logic         skid_load, skid_clear, skid_valid;

    assign pc_inc       = fetch_pc + 32'd4;
    assign resume       = run ? ST_FETCH : ST_IDLE;
    assign mem.i_addr   = fetch_pc;
    assign mem.i_access = (state == ST_FETCH) || (state == ST_FLUSH);
    assign stopped      = !rst && state == ST_IDLE && !run;

    oldland_fetch_skid skid (
        .clk(clk),
        .rst(rst),
        .load(skid_load),
        .clear(skid_clear),
        .d_instr(mem.i_data),
        .d_pc_plus_4(pc_inc),
        .q_instr(skid_instr),
        .q_pc_plus_4(skid_pc_plus_4),
        .valid(skid_valid)
    );

    // state register
    always_ff @(posedge clk) begin
        state <= rst ? ST_IDLE : state_next;
    end

    // next state, PC selection and output source; redirect beats stall and ack
    always_comb begin
        state_next  = state;
        out_sel     = stall ? OUT_KEEP : OUT_BUBBLE;
        pc_next     = fetch_pc;
        target_next = target;
        skid_load   = 1'b0;
        skid_clear  = branch_taken;
        case (state)
            ST_IDLE: begin
                if (branch_taken) begin
                    out_sel = OUT_BUBBLE;
                    pc_next = word_align(branch_pc);
                end else if (pc_wr_en && !run) begin
                    pc_next = word_align(pc_wr_val);
                end
                if (run) state_next = ST_FETCH;
            end
            ST_FETCH: begin
                if (branch_taken) begin
                    out_sel = OUT_BUBBLE;
                    if (mem.i_ack) begin
                        pc_next    = word_align(branch_pc);
                        state_next = resume;
                    end else begin
                        target_next = word_align(branch_pc);
                        state_next  = ST_FLUSH;
                    end
                end else if (mem.i_ack) begin
                    pc_next = pc_inc;
                    if (stall) begin
                        skid_load  = 1'b1;
                        state_next = ST_HOLD;
                    end else begin
                        out_sel    = OUT_MEM;
                        state_next = resume;
                    end
                end
            end
            ST_HOLD: begin
                if (branch_taken) begin
                    out_sel    = OUT_BUBBLE;
                    pc_next    = word_align(branch_pc);
                    state_next = resume;
                end else if (!stall) begin
                    out_sel    = skid_valid ? OUT_SKID : OUT_BUBBLE;
                    skid_clear = 1'b1;
                    state_next = resume;
                end
            end
            default: begin
                out_sel = OUT_BUBBLE;
                if (branch_taken) target_next = word_align(branch_pc);
                if (mem.i_ack) begin
                    pc_next    = branch_taken ? word_align(branch_pc) : target;
                    state_next = resume;
                end
            end
        endcase
    end

    // fetch PC, pending redirect target and the decode-facing output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc  <= RESET_VECTOR;
            target    <= RESET_VECTOR;
            instr     <= NOP_INSTR;
            pc_plus_4 <= 32'd0;
            i_fetched <= 1'b0;
        end else begin
            fetch_pc  <= pc_next;
            target    <= target_next;
            instr     <= out_sel == OUT_MEM ? mem.i_data :
                         out_sel == OUT_SKID ? skid_instr :
                         out_sel == OUT_BUBBLE ? NOP_INSTR : instr;
            pc_plus_4 <= out_sel == OUT_MEM ? pc_inc :
                         out_sel == OUT_SKID ? skid_pc_plus_4 : pc_plus_4;
            i_fetched <= out_sel == OUT_MEM || out_sel == OUT_SKID ? 1'b1 :
                         out_sel == OUT_BUBBLE ? 1'b0 : i_fetched;
        end
    end
endmodule

// File: tb/tb_oldland_fetch.sv
// tb_oldland_fetch: table-driven and scoreboarded checks of the fetch stage
module tb_oldland_fetch;
    import oldland_defs::*;

    localparam logic [31:0] RV = 32'h1000_0000;

    typedef struct {
        logic        run;
        logic        stall;
        int          lat;
        logic        exp_access;
        logic [31:0] exp_addr;
        logic        exp_fetched;
        logic        exp_stopped;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst, stall, branch_taken, run, pc_wr_en, stopped, i_fetched;
    logic [31:0] branch_pc, pc_wr_val, instr, pc_plus_4;

    int          checks = 0, fails = 0;
    int          lat, lat_cnt, drop_acks;
    logic [31:0] req_addr, redirect;
    logic        redirect_pend;
    logic [63:0] sbq[$];
    logic [31:0] prev_instr, prev_pc4;
    logic        prev_fetched;
    vec_t        vecs[8];

    oldland_fetch_if bus();

    oldland_fetch dut (
        .clk(clk),
        .rst(rst),
        .mem(bus),
        .stall(stall),
        .branch_taken(branch_taken),
        .branch_pc(branch_pc),
        .run(run),
        .stopped(stopped),
        .pc_wr_en(pc_wr_en),
        .pc_wr_val(pc_wr_val),
        .instr(instr),
        .pc_plus_4(pc_plus_4),
        .i_fetched(i_fetched)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    function automatic logic [31:0] word(input logic [31:0] a);
        return a ^ 32'hC3C3_3C3C;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // memory model: answers a held request after lat cycles, pushes expected words
    task automatic mem_drive();
        bus.i_ack  = 1'b0;
        bus.i_data = 32'hBAD0_BAD0;
        if (rst || bus.i_access !== 1'b1) begin
            lat_cnt = 0;
        end else if (lat_cnt >= lat - 1) begin
            chk("req_addr", bus.i_addr, req_addr);
            bus.i_ack  = 1'b1;
            bus.i_data = word(bus.i_addr);
            if (drop_acks > 0) drop_acks--;
            else sbq.push_back({word(req_addr), req_addr + 32'd4});
            req_addr      = redirect_pend ? redirect : req_addr + 32'd4;
            redirect_pend = 1'b0;
            lat_cnt       = 0;
        end else begin
            lat_cnt++;
        end
    endtask

    // decode-side monitor: pops scoreboard on each new valid word, checks bubbles/freezes
    task automatic monitor();
        logic [63:0] e;
        if (rst) begin
            chk("rst_fetched", i_fetched, 0);
            chk("rst_instr", instr, OLDLAND_NOP);
            chk("rst_pc4", pc_plus_4, 0);
        end else if (branch_taken) begin
            chk("br_fetched", i_fetched, 0);
            chk("br_instr", instr, OLDLAND_NOP);
        end else if (stall) begin
            chk("frozen_instr", instr, prev_instr);
            chk("frozen_pc4", pc_plus_4, prev_pc4);
            chk("frozen_fetched", i_fetched, prev_fetched);
        end else if (i_fetched) begin
            if (sbq.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL sb_pop: instr %h pc4 %h presented, expected none", instr, pc_plus_4);
            end else begin
                e = sbq.pop_front();
                chk("sb_instr", instr, e[63:32]);
                chk("sb_pc4", pc_plus_4, e[31:0]);
            end
        end else begin
            chk("bubble_instr", instr, OLDLAND_NOP);
        end
        prev_instr   = instr;
        prev_pc4     = pc_plus_4;
        prev_fetched = i_fetched;
    endtask

    task automatic tick();
        mem_drive();
        @(posedge clk);
        #1;
        monitor();
    endtask

    initial begin
        vecs[0] = '{1'b1, 1'b0, 1, 1'b1, RV,             1'b0, 1'b0};
        vecs[1] = '{1'b1, 1'b0, 1, 1'b1, 32'h1000_0004,  1'b1, 1'b0};
        vecs[2] = '{1'b1, 1'b0, 1, 1'b1, 32'h1000_0008,  1'b1, 1'b0};
        vecs[3] = '{1'b1, 1'b0, 1, 1'b1, 32'h1000_000C,  1'b1, 1'b0};
        vecs[4] = '{1'b1, 1'b0, 3, 1'b1, 32'h1000_000C,  1'b0, 1'b0};
        vecs[5] = '{1'b1, 1'b0, 3, 1'b1, 32'h1000_000C,  1'b0, 1'b0};
        vecs[6] = '{1'b1, 1'b0, 3, 1'b1, 32'h1000_0010,  1'b1, 1'b0};
        vecs[7] = '{1'b1, 1'b0, 1, 1'b1, 32'h1000_0014,  1'b1, 1'b0};

        rst = 1'b1; run = 1'b0; stall = 1'b0; branch_taken = 1'b0; branch_pc = '0;
        pc_wr_en = 1'b0; pc_wr_val = '0; bus.i_ack = 1'b0; bus.i_data = '0;
        lat = 1; lat_cnt = 0; drop_acks = 0; redirect = '0; redirect_pend = 1'b0; req_addr = RV;
        repeat (3) tick();
        chk("rst_stopped", stopped, 0);
        chk("rst_access", bus.i_access, 0);
        rst = 1'b0;
        tick();
        chk("idle_stopped", stopped, 1);
        chk("idle_access", bus.i_access, 0);

        // zero-wait stream followed by a 3-cycle latency fetch
        for (int i = 0; i < 8; i++) begin
            run = vecs[i].run; stall = vecs[i].stall; lat = vecs[i].lat;
            tick();
            chk($sformatf("vec%0d_access", i), bus.i_access, vecs[i].exp_access);
            chk($sformatf("vec%0d_addr", i), bus.i_addr, vecs[i].exp_addr);
            chk($sformatf("vec%0d_fetched", i), i_fetched, vecs[i].exp_fetched);
            chk($sformatf("vec%0d_stopped", i), stopped, vecs[i].exp_stopped);
        end

        // stall while ack arrives: word goes to skid, request drops, presented once
        stall = 1'b1;
        tick();
        chk("stall_access", bus.i_access, 0);
        repeat (3) begin
            tick();
            chk("hold_access", bus.i_access, 0);
        end
        stall = 1'b0;
        tick();
        chk("release_access", bus.i_access, 1);
        chk("release_addr", bus.i_addr, 32'h1000_0018);
        tick();

        // redirect while a 2-cycle request is outstanding: flush, then fetch target
        lat = 2; branch_taken = 1'b1; branch_pc = 32'h2000_0041;
        drop_acks = 1; redirect = 32'h2000_0040; redirect_pend = 1'b1;
        tick();
        chk("flush_addr", bus.i_addr, 32'h1000_001C);
        chk("flush_access", bus.i_access, 1);
        branch_taken = 1'b0;
        tick();
        chk("redirect_addr", bus.i_addr, 32'h2000_0040);
        tick();
        tick();
        chk("redirect_fetched", i_fetched, 1);
        chk("redirect_pc4", pc_plus_4, 32'h2000_0044);

        // redirect in the same cycle as an ack
        lat = 1; branch_taken = 1'b1; branch_pc = 32'h3000_0000;
        drop_acks = 1; redirect = 32'h3000_0000; redirect_pend = 1'b1;
        tick();
        chk("br_ack_addr", bus.i_addr, 32'h3000_0000);
        branch_taken = 1'b0;
        tick();

        // second redirect while flushing replaces the target
        lat = 3; branch_taken = 1'b1; branch_pc = 32'h4000_0000;
        drop_acks = 1; redirect = 32'h4000_0000; redirect_pend = 1'b1;
        tick();
        branch_pc = 32'h5000_0000; redirect = 32'h5000_0000;
        tick();
        branch_taken = 1'b0;
        tick();
        chk("double_br_addr", bus.i_addr, 32'h5000_0000);
        lat = 1;
        tick();

        // run low mid-request: outstanding word delivered, then stop
        lat = 2; run = 1'b0;
        tick();
        chk("stop_pending_access", bus.i_access, 1);
        tick();
        chk("stop_access", bus.i_access, 0);
        chk("stop_stopped", stopped, 1);
        chk("stop_fetched", i_fetched, 1);
        tick();
        pc_wr_en = 1'b1; pc_wr_val = 32'h0000_0100;
        tick();
        pc_wr_en = 1'b0; req_addr = 32'h0000_0100; run = 1'b1; lat = 1;
        tick();
        chk("pcwr_addr", bus.i_addr, 32'h0000_0100);
        chk("pcwr_stopped", stopped, 0);
        pc_wr_en = 1'b1; pc_wr_val = 32'h0000_0500;
        tick();
        chk("pcwr_ignored", bus.i_addr, 32'h0000_0104);
        pc_wr_en = 1'b0;
        tick();

        // PC wrap at the top of the address space
        run = 1'b0;
        tick();
        tick();
        pc_wr_en = 1'b1; pc_wr_val = 32'hFFFF_FFF8;
        tick();
        pc_wr_en = 1'b0; req_addr = 32'hFFFF_FFF8; run = 1'b1;
        tick();
        tick();
        tick();
        chk("wrap_addr", bus.i_addr, 32'h0000_0000);
        chk("wrap_pc4", pc_plus_4, 32'h0000_0000);

        // reset during an outstanding request
        lat = 3;
        tick();
        rst = 1'b1;
        tick();
        chk("midrst_access", bus.i_access, 0);
        chk("midrst_stopped", stopped, 0);
        rst = 1'b0; lat = 1; req_addr = RV;
        tick();
        chk("postrst_addr", bus.i_addr, RV);
        chk("postrst_access", bus.i_access, 1);
        tick();
        chk("postrst_pc4", pc_plus_4, RV + 32'd4);

        run = 1'b0;
        repeat (3) tick();
        chk("sb_drained", sbq.size(), 0);
        chk("final_stopped", stopped, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
